// File: rtl/mul_add_pkg.sv
// Shared types and constants for the annealer energy multiply-add sequencer.
// Field layout of the packed operand word and the per-phase operand selection.
package mul_add_pkg;

  localparam int OPND_W = 16;
  localparam int WORD_W = 96;
  localparam int PROD_W = 32;

  localparam int X1_LSB = 80;
  localparam int X2_LSB = 64;
  localparam int X3_LSB = 48;
  localparam int X4_LSB = 32;
  localparam int X5_LSB = 16;
  localparam int X6_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_P2,
    S_P3,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_X1X2,
    SEL_X3X4,
    SEL_X4X5
  } opsel_t;

  // x6 never reaches the multiplier, so it is not part of the latched operands.
  typedef struct packed {
    logic [OPND_W-1:0] x1;
    logic [OPND_W-1:0] x2;
    logic [OPND_W-1:0] x3;
    logic [OPND_W-1:0] x4;
    logic [OPND_W-1:0] x5;
  } opnd_t;

  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } mul_req_t;

  function automatic opnd_t unpack_word(input logic [WORD_W-1:0] w);
    opnd_t o;
    o.x1 = w[X1_LSB +: OPND_W];
    o.x2 = w[X2_LSB +: OPND_W];
    o.x3 = w[X3_LSB +: OPND_W];
    o.x4 = w[X4_LSB +: OPND_W];
    o.x5 = w[X5_LSB +: OPND_W];
    return o;
  endfunction

  function automatic opsel_t state_opsel(input state_t s);
    case (s)
      S_P1:    return SEL_X1X2;
      S_P2:    return SEL_X3X4;
      S_P3:    return SEL_X4X5;
      default: return SEL_NONE;
    endcase
  endfunction

  function automatic mul_req_t select_operands(input opsel_t sel, input opnd_t o);
    mul_req_t r;
    r = '0;
    case (sel)
      SEL_X1X2: begin r.a = o.x1; r.b = o.x2; end
      SEL_X3X4: begin r.a = o.x3; r.b = o.x4; end
      SEL_X4X5: begin r.a = o.x4; r.b = o.x5; end
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mul16_u.sv
// Combinational 16x16 unsigned multiplier; single shared instance so the
// sequencer maps onto one DSP slice.
module mul16_u
  import mul_add_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  assign p = {{(PROD_W-OPND_W){1'b0}}, a} * {{(PROD_W-OPND_W){1'b0}}, b};

endmodule

// File: rtl/mul_add_seq.sv
// Time-multiplexed frame multiply-add: three products per word on one multiplier,
// summed over FRAME_LEN words. Define MULADD_SAT_EN for a clamping accumulator + out_sat.
module mul_add_seq
  import mul_add_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              busy
`ifdef MULADD_SAT_EN
  ,
  output logic              out_sat
`endif
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_LEN - 1);

  state_t            state;
  opnd_t             opnd_q;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  word_cnt;
  mul_req_t          mreq;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  acc_nxt;
  logic              unused_x6;

  assign unused_x6 = ^in_data[X6_LSB +: OPND_W];

  assign mreq = select_operands(state_opsel(state), opnd_q);

  mul16_u u_mul (
    .a (mreq.a),
    .b (mreq.b),
    .p (prod)
  );

  assign prod_ext = {{(ACC_W-PROD_W){1'b0}}, prod};

`ifdef MULADD_SAT_EN
  logic [ACC_W:0] sum_w;
  logic           clamp;
  logic           sat_q;

  assign sum_w   = {1'b0, acc} + {1'b0, prod_ext};
  assign clamp   = sum_w[ACC_W];
  assign acc_nxt = clamp ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
  assign out_sat = sat_q;

  // Sticky until the frame sum is handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (state == S_DONE) begin
      if (out_ready) sat_q <= 1'b0;
    end else if (state == S_P1 || state == S_P2 || state == S_P3) begin
      if (clamp) sat_q <= 1'b1;
    end
  end
`else
  assign acc_nxt = acc + prod_ext;
`endif

  assign out_sum = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      opnd_q    <= '0;
      acc       <= '0;
      word_cnt  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            opnd_q   <= unpack_word(in_data);
            state    <= S_P1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_P1: begin
          acc   <= acc_nxt;
          state <= S_P2;
        end
        S_P2: begin
          acc   <= acc_nxt;
          state <= S_P3;
        end
        S_P3: begin
          acc <= acc_nxt;
          if (word_cnt == LAST_WORD) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            word_cnt <= word_cnt + CNT_W'(1);
            state    <= S_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        S_DONE: begin
          // IDLE is always re-entered before the next word is taken.
          if (out_ready) begin
            acc       <= '0;
            word_cnt  <= '0;
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_add_seq.sv
// Directed bench for mul_add_seq: three instances (8/40, 2/34, 1/40) sharing
// clock, reset and stimulus, selected one at a time.
module tb_mul_add_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic [95:0] data = '0;

  logic        ir0, ov0, b0;
  logic [39:0] s0;
  logic        ir1, ov1, b1;
  logic [33:0] s1;
  logic        ir2, ov2, b2;
  logic [39:0] s2;
`ifdef MULADD_SAT_EN
  logic        sat0, sat1, sat2;
`endif

  logic        cur_ir, cur_ov, cur_busy;
  logic [63:0] cur_sum;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_add_seq #(.FRAME_LEN(8), .ACC_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2'd0), .in_ready(ir0),
    .in_data(data), .out_valid(ov0), .out_ready(ordy && sel == 2'd0),
    .out_sum(s0), .busy(b0)
`ifdef MULADD_SAT_EN
    , .out_sat(sat0)
`endif
  );

  mul_add_seq #(.FRAME_LEN(2), .ACC_W(34)) dut_ov (
    .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2'd1), .in_ready(ir1),
    .in_data(data), .out_valid(ov1), .out_ready(ordy && sel == 2'd1),
    .out_sum(s1), .busy(b1)
`ifdef MULADD_SAT_EN
    , .out_sat(sat1)
`endif
  );

  mul_add_seq #(.FRAME_LEN(1), .ACC_W(40)) dut_f1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2'd2), .in_ready(ir2),
    .in_data(data), .out_valid(ov2), .out_ready(ordy && sel == 2'd2),
    .out_sum(s2), .busy(b2)
`ifdef MULADD_SAT_EN
    , .out_sat(sat2)
`endif
  );

  always_comb begin
    case (sel)
      2'd1:    begin cur_ir = ir1; cur_ov = ov1; cur_busy = b1; cur_sum = {30'd0, s1}; end
      2'd2:    begin cur_ir = ir2; cur_ov = ov2; cur_busy = b2; cur_sum = {24'd0, s2}; end
      default: begin cur_ir = ir0; cur_ov = ov0; cur_busy = b0; cur_sum = {24'd0, s0}; end
    endcase
  end

  typedef struct {
    logic [15:0] x1, x2, x3, x4, x5, x6;
    logic [63:0] exp_sum;
  } vec_t;

  function automatic logic [95:0] mk(input logic [15:0] x1, x2, x3, x4, x5, x6);
    return {x1, x2, x3, x4, x5, x6};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic [95:0] d);
    bit done;
    done = 1'b0;
    data = d;
    iv   = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (cur_ir) done = 1'b1;
      tick();
    end
    iv = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_ov();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (cur_ov) seen = 1'b1;
      else tick();
    end
    if (!seen) chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic pop();
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin
    int cnt_ir;
    int cyc;
    logic [63:0] held;

    vecs[0] = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 64'd56};
    vecs[1] = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 64'd3};
    vecs[2] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd9, 64'd0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 64'd4294836225};
    vecs[4] = '{16'd0, 16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 64'd8589672450};
    vecs[5] = '{16'd7, 16'd0, 16'd0, 16'd9, 16'd3, 16'd0, 64'd27};
    vecs[6] = '{16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'hFFFF, 64'd12};
    vecs[7] = '{16'd0, 16'd0, 16'd2, 16'd3, 16'd5, 16'd0, 64'd21};

    repeat (2) tick();
    chk("rst_in_ready", {63'd0, cur_ir}, 64'd1);
    chk("rst_out_valid", {63'd0, cur_ov}, 64'd0);
    chk("rst_busy", {63'd0, cur_busy}, 64'd0);
    chk("rst_out_sum", cur_sum, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single frame, continuous offer: in_ready high 1 of 4 cycles, sum after 32 edges.
    sel = 2'd0; ordy = 1'b1; data = mk(2, 3, 4, 5, 6, 7); iv = 1'b1;
    cnt_ir = 0; cyc = -1;
    for (int i = 0; i < 40 && cyc < 0; i++) begin
      if (cur_ov) cyc = i;
      else begin
        if (cur_ir) cnt_ir++;
        tick();
      end
    end
    iv = 1'b0;
    chk("f8_cycles", 64'(cyc), 64'd32);
    chk("f8_in_ready_cnt", 64'(cnt_ir), 64'd8);
    chk("f8_sum", cur_sum, 64'd448);
    tick();
    ordy = 1'b0;
    chk("f8_ov_one_cycle", {63'd0, cur_ov}, 64'd0);
    chk("f8_back_idle", {63'd0, cur_ir}, 64'd1);

    // Max operands, with latency and backpressure.
    for (int w = 0; w < 8; w++) send(mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
    tick(); tick();
    chk("lat_ov_early", {63'd0, cur_ov}, 64'd0);
    tick();
    chk("lat_ov_rise", {63'd0, cur_ov}, 64'd1);
    chk("max_sum", cur_sum, 64'd103076069400);
    held = cur_sum;
    data = mk(1, 1, 1, 1, 1, 1); iv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_sum_stable", cur_sum, held);
      chk("bp_in_ready", {63'd0, cur_ir}, 64'd0);
      chk("bp_ov_held", {63'd0, cur_ov}, 64'd1);
    end
    iv = 1'b0;
    pop();
    chk("bp_rel_ov", {63'd0, cur_ov}, 64'd0);
    chk("bp_rel_ir", {63'd0, cur_ir}, 64'd1);
    chk("bp_rel_acc", cur_sum, 64'd0);
    tick();
    chk("bp_no_consume", {63'd0, cur_busy}, 64'd0);

    // Reset during P2 of the third word.
    send(mk(2, 3, 4, 5, 6, 7));
    send(mk(2, 3, 4, 5, 6, 7));
    send(mk(2, 3, 4, 5, 6, 7));
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_ov", {63'd0, cur_ov}, 64'd0);
    chk("mrst_busy", {63'd0, cur_busy}, 64'd0);
    chk("mrst_acc", cur_sum, 64'd0);
    chk("mrst_ir", {63'd0, cur_ir}, 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    for (int w = 0; w < 8; w++) send(mk(2, 3, 4, 5, 6, 7));
    wait_ov();
    chk("mrst_next_frame", cur_sum, 64'd448);
    pop();

    // Overflow: ACC_W=34, FRAME_LEN=2.
    sel = 2'd1;
    send(mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
    send(mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
    wait_ov();
`ifdef MULADD_SAT_EN
    chk("ovf_sum_sat", cur_sum, 64'd17179869183);
    chk("ovf_sat_flag", {63'd0, sat1}, 64'd1);
    pop();
    chk("ovf_sat_clear", {63'd0, sat1}, 64'd0);
`else
    chk("ovf_sum_wrap", cur_sum, 64'd8589148166);
    pop();
`endif
    chk("ovf_acc_clear", cur_sum, 64'd0);

    // Table of single-word frames.
    sel = 2'd2;
    foreach (vecs[k]) begin
      send(mk(vecs[k].x1, vecs[k].x2, vecs[k].x3, vecs[k].x4, vecs[k].x5, vecs[k].x6));
      wait_ov();
      chk($sformatf("vec%0d_sum", k), cur_sum, vecs[k].exp_sum);
      pop();
      chk($sformatf("vec%0d_ov_low", k), {63'd0, cur_ov}, 64'd0);
    end

    // FRAME_LEN=1 back-to-back: second word waits for first sum's handshake.
    send(mk(2, 3, 4, 5, 6, 0));
    data = mk(1, 1, 1, 1, 1, 0); iv = 1'b1;
    wait_ov();
    chk("b2b_first", cur_sum, 64'd56);
    tick(); tick();
    chk("b2b_hold_ir", {63'd0, cur_ir}, 64'd0);
    chk("b2b_hold_sum", cur_sum, 64'd56);
    pop();
    chk("b2b_idle_ir", {63'd0, cur_ir}, 64'd1);
    chk("b2b_idle_ov", {63'd0, cur_ov}, 64'd0);
    tick();
    iv = 1'b0;
    chk("b2b_second_taken", {63'd0, cur_busy}, 64'd1);
    wait_ov();
    chk("b2b_second", cur_sum, 64'd3);
    pop();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
